// File: rtl/mcs4_addr_stack.sv
// Program counter and circular return-address stack for the MCS-4 core.
// Define MCS4_STACK_GUARD_EN to block stack writes on overflow and pops on underflow.
module mcs4_addr_stack #(
    parameter int ADDR_W = 12,
    parameter int PAGE_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    input  logic [2:0]                 cmd,
    input  logic [ADDR_W-1:0]          target,
    input  logic                       clr_flags,
    output logic [ADDR_W-1:0]          pc,
    output logic [ADDR_W-1:0]          pc_inc,
    output logic                       end_of_page,
    output logic [ADDR_W-1:0]          top,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       ovf,
    output logic                       udf
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [2:0] {
        CMD_ADV       = 3'd0,
        CMD_JUMP      = 3'd1,
        CMD_JUMP_PAGE = 3'd2,
        CMD_CALL      = 3'd3,
        CMD_RET       = 3'd4
    } cmd_e;

    logic [ADDR_W-1:0] stack [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;

    logic [ADDR_W-1:0] pc_nxt;
    logic [PTR_W-1:0]  wr_ptr_nxt;
    logic [LVL_W-1:0]  level_nxt;
    logic              push, set_ovf, set_udf;
    logic              full, empty;

    assign pc_inc      = pc + ADDR_W'(1);
    assign end_of_page = &pc[PAGE_W-1:0];
    assign rd_ptr      = wr_ptr - PTR_W'(1);
    assign top         = stack[rd_ptr];
    assign full        = (level == LVL_W'(DEPTH));
    assign empty       = (level == '0);

    always_comb begin
        pc_nxt     = pc;
        wr_ptr_nxt = wr_ptr;
        level_nxt  = level;
        push       = 1'b0;
        set_ovf    = 1'b0;
        set_udf    = 1'b0;
        if (cmd_valid) begin
            case (cmd)
                CMD_JUMP:      pc_nxt = target;
                CMD_JUMP_PAGE: pc_nxt = {pc_inc[ADDR_W-1:PAGE_W], target[PAGE_W-1:0]};
                CMD_CALL: begin
                    pc_nxt  = target;
                    set_ovf = full;
`ifdef MCS4_STACK_GUARD_EN
                    if (!full) begin
                        push       = 1'b1;
                        wr_ptr_nxt = wr_ptr + PTR_W'(1);
                        level_nxt  = level + LVL_W'(1);
                    end
`else
                    push       = 1'b1;
                    wr_ptr_nxt = wr_ptr + PTR_W'(1);
                    if (!full) level_nxt = level + LVL_W'(1);
`endif
                end
                CMD_RET: begin
                    set_udf = empty;
`ifdef MCS4_STACK_GUARD_EN
                    if (empty) begin
                        pc_nxt = pc_inc;
                    end else begin
                        pc_nxt     = stack[rd_ptr];
                        wr_ptr_nxt = rd_ptr;
                        level_nxt  = level - LVL_W'(1);
                    end
`else
                    pc_nxt     = stack[rd_ptr];
                    wr_ptr_nxt = rd_ptr;
                    if (!empty) level_nxt = level - LVL_W'(1);
`endif
                end
                default:       pc_nxt = pc_inc;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc     <= '0;
            wr_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) stack[i] <= '0;
        end else begin
            pc     <= pc_nxt;
            wr_ptr <= wr_ptr_nxt;
            level  <= level_nxt;
            // a flag being set in this cycle takes precedence over clr_flags
            ovf    <= set_ovf | (ovf & ~clr_flags);
            udf    <= set_udf | (udf & ~clr_flags);
            if (push) stack[wr_ptr] <= pc_inc;
        end
    end

endmodule

// File: tb/tb_mcs4_addr_stack.sv
// Directed self-checking bench for mcs4_addr_stack (ADDR_W=12, PAGE_W=8, DEPTH=4).
module tb_mcs4_addr_stack;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [2:0]  cmd = 3'd0;
    logic [11:0] target = '0;
    logic        clr_flags = 1'b0;
    logic [11:0] pc, pc_inc, top;
    logic        end_of_page, ovf, udf;
    logic [2:0]  level;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] ADV = 3'd0, JUMP = 3'd1, JPAGE = 3'd2, CALL = 3'd3, RET = 3'd4;

    always #5 clk = ~clk;

    mcs4_addr_stack #(.ADDR_W(12), .PAGE_W(8), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd(cmd), .target(target),
        .clr_flags(clr_flags), .pc(pc), .pc_inc(pc_inc), .end_of_page(end_of_page),
        .top(top), .level(level), .ovf(ovf), .udf(udf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // drive one cycle of inputs, sample 1 time unit after the edge
    task automatic issue(input logic v, input logic [2:0] c, input logic [11:0] t, input logic clr);
        @(negedge clk);
        cmd_valid = v; cmd = c; target = t; clr_flags = clr;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0; clr_flags = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        issue(1'b0, ADV, '0, 1'b0);
        issue(1'b0, ADV, '0, 1'b0);
        rst_n = 1'b1;
        chk("reset_pc", pc, 0);
        chk("reset_level", level, 0);
        chk("reset_ovf", ovf, 0);
        chk("reset_udf", udf, 0);
        chk("reset_top", top, 0);

        issue(1'b1, ADV, '0, 1'b0);
        issue(1'b1, ADV, '0, 1'b0);
        issue(1'b1, ADV, '0, 1'b0);
        chk("adv3_pc", pc, 12'h003);
        chk("adv3_level", level, 0);
        chk("adv3_flags", {ovf, udf}, 0);

        issue(1'b0, JUMP, 12'h555, 1'b0);
        chk("idle_hold_pc", pc, 12'h003);
        issue(1'b1, 3'd6, 12'h555, 1'b0);
        chk("reserved_is_adv", pc, 12'h004);

        issue(1'b1, JUMP, 12'h0FF, 1'b0);
        chk("jump_pc", pc, 12'h0FF);
        chk("eop_high", end_of_page, 1);
        issue(1'b1, JPAGE, 12'h042, 1'b0);
        chk("jpage_next_page", pc, 12'h142);
        chk("eop_low", end_of_page, 0);

        issue(1'b1, JUMP, 12'hFFF, 1'b0);
        chk("pc_inc_wrap", pc_inc, 12'h000);
        issue(1'b1, ADV, '0, 1'b0);
        chk("adv_wrap", pc, 12'h000);

        issue(1'b1, JUMP, 12'h010, 1'b0);
        issue(1'b1, CALL, 12'h200, 1'b0);
        chk("call1_pc", pc, 12'h200);
        chk("call1_top", top, 12'h011);
        issue(1'b1, CALL, 12'h300, 1'b0);
        chk("call2_level", level, 2);
        chk("call2_top", top, 12'h201);
        issue(1'b1, RET, '0, 1'b0);
        chk("ret1_pc", pc, 12'h201);
        chk("ret1_level", level, 1);
        issue(1'b1, RET, '0, 1'b0);
        chk("ret2_pc", pc, 12'h011);
        chk("ret2_level", level, 0);
        chk("ret2_flags", {ovf, udf}, 0);

        // five nested calls on a four-deep stack
        issue(1'b1, JUMP, 12'h100, 1'b0);
        issue(1'b1, CALL, 12'h400, 1'b0);
        issue(1'b1, CALL, 12'h500, 1'b0);
        issue(1'b1, CALL, 12'h600, 1'b0);
        issue(1'b1, CALL, 12'h700, 1'b0);
        chk("full_level", level, 4);
        chk("full_no_ovf", ovf, 0);
        issue(1'b1, CALL, 12'h800, 1'b0);
        chk("call5_pc", pc, 12'h800);
        chk("call5_level", level, 4);
        chk("call5_ovf", ovf, 1);
`ifdef MCS4_STACK_GUARD_EN
        chk("call5_top", top, 12'h601);
        issue(1'b1, RET, '0, 1'b0); chk("oret1_pc", pc, 12'h601);
        issue(1'b1, RET, '0, 1'b0); chk("oret2_pc", pc, 12'h501);
        issue(1'b1, RET, '0, 1'b0); chk("oret3_pc", pc, 12'h401);
        issue(1'b1, RET, '0, 1'b0); chk("oret4_pc", pc, 12'h101);
        chk("oret4_udf", udf, 0);
        issue(1'b1, RET, '0, 1'b0); chk("oret5_pc", pc, 12'h102);
`else
        chk("call5_top", top, 12'h701);
        issue(1'b1, RET, '0, 1'b0); chk("oret1_pc", pc, 12'h701);
        issue(1'b1, RET, '0, 1'b0); chk("oret2_pc", pc, 12'h601);
        issue(1'b1, RET, '0, 1'b0); chk("oret3_pc", pc, 12'h501);
        issue(1'b1, RET, '0, 1'b0); chk("oret4_pc", pc, 12'h401);
        chk("oret4_udf", udf, 0);
        issue(1'b1, RET, '0, 1'b0); chk("oret5_pc", pc, 12'h701);
`endif
        chk("oret5_udf", udf, 1);
        chk("oret5_level", level, 0);
        chk("ovf_sticky", ovf, 1);

        issue(1'b0, ADV, '0, 1'b1);
        chk("clr_flags", {ovf, udf}, 0);

        // reset beats a same-cycle CALL and clears saved addresses
        issue(1'b1, JUMP, 12'h123, 1'b0);
        issue(1'b1, CALL, 12'h234, 1'b0);
        rst_n = 1'b0;
        issue(1'b1, CALL, 12'h345, 1'b0);
        rst_n = 1'b1;
        chk("rstcall_pc", pc, 0);
        chk("rstcall_level", level, 0);
        chk("rstcall_top", top, 0);
        issue(1'b1, RET, '0, 1'b0);
`ifdef MCS4_STACK_GUARD_EN
        chk("rst_ret_pc", pc, 12'h001);
`else
        chk("rst_ret_pc", pc, 12'h000);
`endif
        chk("rst_ret_udf", udf, 1);

        rst_n = 1'b0;
        issue(1'b0, ADV, '0, 1'b0);
        rst_n = 1'b1;
        issue(1'b1, CALL, 12'h010, 1'b0);
        issue(1'b1, CALL, 12'h020, 1'b0);
        issue(1'b1, CALL, 12'h030, 1'b0);
        issue(1'b1, CALL, 12'h040, 1'b0);
        issue(1'b1, CALL, 12'h050, 1'b1);
        chk("set_beats_clr", ovf, 1);
        issue(1'b0, ADV, '0, 1'b1);
        chk("clr_after_set", ovf, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mcs4_addr_stack.md
# mcs4_addr_stack

Parametrised program-counter and subroutine-stack unit for the next-generation MCS-4 core. It replaces the fixed 12-bit, 4-entry address register with a configurable address width and stack depth, so one block covers both 4004-class and 4040-class call nesting. The unit has a one-command-per-cycle interface driven by the core's instruction-cycle sequencer. It also provides page-relative jumps, end-of-page detection, level tracking and overflow/underflow reporting.

## Interface
- ADDR_W, 12, program address width in bits; must be > PAGE_W.
- PAGE_W, 8, in-page offset width; a page is 2^PAGE_W words.
- DEPTH, 4, number of saved return addresses; power of two, at least 2.
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command strobe; one command is accepted per cycle in which this is high.
- cmd  in  3  opcode: 0 ADV, 1 JUMP, 2 JUMP_PAGE, 3 CALL, 4 RET, 5–7 reserved (treated as ADV).
- target  in  ADDR_W  jump/call destination; JUMP_PAGE uses only target[PAGE_W-1:0].
- pc  out  ADDR_W  current program address.
- pc_inc  out  ADDR_W  combinational pc+1, modulo 2^ADDR_W.
- end_of_page  out  1  high when pc[PAGE_W-1:0] is all ones.
- top  out  ADDR_W  most recently pushed return address (the entry at wr_ptr-1).
- level  out  $clog2(DEPTH)+1  number of valid saved entries, 0..DEPTH.
- ovf  out  1  sticky; set by a CALL while level==DEPTH.
- udf  out  1  sticky; set by a RET while level==0.
- clr_flags  in  1  clears ovf/udf; a set in the same cycle wins over the clear.

## Operation
- The stack is a circular buffer of DEPTH entries with write pointer wr_ptr, modulo DEPTH.
- ADV: pc <= pc_inc.
- JUMP: pc <= target.
- JUMP_PAGE: pc <= {pc_inc[ADDR_W-1:PAGE_W], target[PAGE_W-1:0]}.
  - The page comes from pc_inc, so a page jump issued at the last word of a page lands in the next page. This is the 4004 JCN/ISZ/FIN rule.
- CALL: stack[wr_ptr] <= pc_inc; wr_ptr <= wr_ptr+1; pc <= target; level <= min(level+1, DEPTH).
- RET: wr_ptr <= wr_ptr-1; pc <= stack[wr_ptr-1]; level <= max(level-1, 0).
- Full stack, CALL: overwrites the oldest entry (circular behaviour), level stays DEPTH, ovf set.
- Empty stack, RET: pops the stale entry from the circular buffer, level stays 0, udf set.
- cmd_valid low: all state holds.
- Address arithmetic wraps: pc = 2^ADDR_W-1 plus ADV gives 0.
- Reset (rst_n low at an edge): pc=0, wr_ptr=0, level=0, ovf=0, udf=0, all stack entries 0.
  - Reset takes priority over any command issued in the same cycle.
  - Reset mid-call-sequence discards all saved addresses.

## Timing
- All outputs are registered except pc_inc, end_of_page and top, which decode registered state combinationally.
- Latency is one cycle: a command accepted at edge N is visible on pc/level/flags after edge N.
- Back-to-back commands are allowed every cycle.
  - CALL then RET on consecutive cycles returns to the CALL's pc_inc.
- No backpressure; there is no ready signal.

## Configuration
- MCS4_STACK_GUARD_EN defined:
  - CALL on a full stack does not write the stack or move wr_ptr; pc still goes to target; ovf is set.
  - RET on an empty stack behaves as ADV (pc <= pc_inc); udf is set.
- MCS4_STACK_GUARD_EN undefined:
  - Pure circular behaviour as described in Operation.
  - ovf/udf are still reported.

## Test plan
- Reset, then 3 ADV (ADDR_W=12) -> pc=0x003, level=0, flags 0.
- JUMP 0x0FF, then JUMP_PAGE target 0x042 -> pc=0x142, and end_of_page high while pc=0x0FF.
- JUMP 0xFFF, then ADV -> pc=0x000 (wrap).
- From pc=0x010, CALL 0x200 then CALL 0x300 -> level=2, top=0x201; RET -> pc=0x201; RET -> pc=0x011, level=0.
- DEPTH=4, 5 nested CALLs, then 5 RETs:
  - guard off: ovf=1, and the 5th RET returns the wrapped (overwritten) entry;
  - guard on: ovf=1, the first 4 RETs return the 4 surviving entries, and the 5th RET gives udf=1 with pc=pc+1.
- CALL issued with rst_n low -> pc=0, level=0, stack untouched by the CALL; ovf set and clr_flags in the same cycle -> ovf=1.
